alu_seq_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences the shared 32-bit ALU, data memory and register file for one instruction at a time.
- Accepts an instruction word from fetch over a valid/ready handshake and decodes it.
- Drives the 4-bit ALU control code and the datapath enables per cycle.
- Retires each instruction with a one-cycle done pulse; sits between fetch and the datapath in the core.

---
 rtl/alu_seq_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle ALU/memory/regfile sequencing FSM, one instruction at a time
// Optional memory-wait timeout: ALU_SEQ_MEM_TIMEOUT_EN
module alu_seq_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ack,
  output logic [3:0]  alu_ctrl,
  output logic        alu_src_imm,
  output logic        mem_req,
  output logic        mem_we,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        done,
  output logic        illegal,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_MEM_WAIT, S_WB, S_JUMP
  } state_t;

  typedef enum logic [2:0] {
    K_ADDU, K_OR, K_ADDIU, K_LW, K_SW, K_JAL, K_BNE, K_ILL
  } kind_t;

  state_t     state;
  kind_t      kind;
  logic [5:0] ir_op;
  logic [5:0] ir_funct;
  logic [3:0] kind_code;

  // Only opcode and funct steer the sequence; the remaining fields belong to the datapath.
  logic unused_instr;
  assign unused_instr = ^instr[25:6];

  always_comb begin
    kind = K_ILL;
    case (ir_op)
      6'h00: begin
        if (ir_funct == 6'h21)      kind = K_ADDU;
        else if (ir_funct == 6'h25) kind = K_OR;
      end
      6'h09:   kind = K_ADDIU;
      6'h2B:   kind = K_SW;
      6'h23:   kind = K_LW;
      6'h03:   kind = K_JAL;
      6'h05:   kind = K_BNE;
      default: kind = K_ILL;
    endcase
  end

  always_comb begin
    kind_code = 4'b0000;
    case (kind)
      K_ADDIU: kind_code = 4'b0000;
      K_SW:    kind_code = 4'b0001;
      K_ADDU:  kind_code = 4'b0010;
      K_JAL:   kind_code = 4'b0011;
      K_LW:    kind_code = 4'b0100;
      K_OR:    kind_code = 4'b0101;
      K_BNE:   kind_code = 4'b0110;
      default: kind_code = 4'b0000;
    endcase
  end

`ifdef ALU_SEQ_MEM_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;
`else
  logic [CNT_W-1:0] unused_cfg;
  assign unused_cfg = CNT_W'(MEM_TIMEOUT);
  assign bus_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ir_op       <= 6'd0;
      ir_funct    <= 6'd0;
      instr_ready <= 1'b0;
      alu_ctrl    <= 4'b0000;
      alu_src_imm <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      reg_we      <= 1'b0;
      reg_dst     <= 2'd0;
      wb_sel      <= 2'd0;
      pc_we       <= 1'b0;
      pc_sel      <= 2'd0;
      done        <= 1'b0;
      illegal     <= 1'b0;
`ifdef ALU_SEQ_MEM_TIMEOUT_EN
      wait_cnt    <= '0;
      bus_err     <= 1'b0;
`endif
    end else begin
      reg_we  <= 1'b0;
      pc_we   <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      reg_dst <= 2'd0;
      wb_sel  <= 2'd0;
      pc_sel  <= 2'd0;
`ifdef ALU_SEQ_MEM_TIMEOUT_EN
      bus_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          alu_ctrl    <= 4'b0000;
          alu_src_imm <= 1'b0;
          // Ready is re-armed one cycle after retire, so the retire cycle itself never accepts.
          if (instr_ready && instr_valid) begin
            ir_op       <= instr[31:26];
            ir_funct    <= instr[5:0];
            instr_ready <= 1'b0;
            state       <= S_DECODE;
          end else begin
            instr_ready <= 1'b1;
          end
        end
        S_DECODE: begin
          if (kind == K_ILL) begin
            illegal <= 1'b1;
            state   <= S_IDLE;
          end else begin
            alu_ctrl    <= kind_code;
            alu_src_imm <= (kind == K_ADDIU) || (kind == K_LW) || (kind == K_SW);
            state       <= (kind == K_JAL) ? S_JUMP : S_EXEC;
          end
        end
        S_EXEC: begin
          if (kind == K_BNE) begin
            pc_we  <= 1'b1;
            pc_sel <= alu_zero ? 2'd0 : 2'd1;
            done   <= 1'b1;
            state  <= S_IDLE;
          end else if (kind == K_LW || kind == K_SW) begin
            mem_req <= 1'b1;
            mem_we  <= (kind == K_SW);
            state   <= S_MEM_WAIT;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
`ifdef ALU_SEQ_MEM_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            if (kind == K_SW) begin
              pc_we <= 1'b1;
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_WB;
            end
          end
`ifdef ALU_SEQ_MEM_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            bus_err  <= 1'b1;
            wait_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_WB: begin
          reg_we  <= 1'b1;
          pc_we   <= 1'b1;
          done    <= 1'b1;
          reg_dst <= (kind == K_ADDU || kind == K_OR) ? 2'd1 : 2'd0;
          wb_sel  <= (kind == K_LW) ? 2'd1 : 2'd0;
          state   <= S_IDLE;
        end
        S_JUMP: begin
          reg_we  <= 1'b1;
          reg_dst <= 2'd2;
          wb_sel  <= 2'd2;
          pc_we   <= 1'b1;
          pc_sel  <= 2'd2;
          done    <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - randomized bench for alu_seq_ctrl against a per-instruction behavioural model
module tb_alu_seq_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        alu_zero;
  logic        mem_ack;
  logic [3:0]  alu_ctrl;
  logic        alu_src_imm;
  logic        mem_req;
  logic        mem_we;
  logic        reg_we;
  logic [1:0]  reg_dst;
  logic [1:0]  wb_sel;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        done;
  logic        illegal;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_zero(alu_zero), .mem_ack(mem_ack), .alu_ctrl(alu_ctrl),
    .alu_src_imm(alu_src_imm), .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .done(done),
    .illegal(illegal), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0] code;
    logic       imm;
    int         lat;
    int         nreg;
    int         npc;
    int         ndone;
    int         nill;
    int         nbus;
    int         nreq;
    int         nwe;
    logic [1:0] dst;
    logic [1:0] wb;
    logic [1:0] ps;
  } exp_t;

  // Expected behaviour of one instruction, measured in cycles after the acceptance cycle.
  function automatic exp_t model(input logic [31:0] w, input logic zero, input int wait_n);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    bit mem;
    bit sw;
    op = w[31:26];
    fn = w[5:0];
    e = '{code: 4'd0, imm: 1'b0, lat: 0, nreg: 0, npc: 1, ndone: 1, nill: 0, nbus: 0,
          nreq: 0, nwe: 0, dst: 2'd0, wb: 2'd0, ps: 2'd0};
    mem = 0;
    sw  = 0;
    if (op == 6'h00 && fn == 6'h21) begin e.code = 4'b0010; e.lat = 4; e.nreg = 1; e.dst = 2'd1; end
    else if (op == 6'h00 && fn == 6'h25) begin e.code = 4'b0101; e.lat = 4; e.nreg = 1; e.dst = 2'd1; end
    else if (op == 6'h09) begin e.code = 4'b0000; e.imm = 1; e.lat = 4; e.nreg = 1; end
    else if (op == 6'h23) begin e.code = 4'b0100; e.imm = 1; e.lat = 4 + wait_n; e.nreg = 1; e.wb = 2'd1; mem = 1; end
    else if (op == 6'h2B) begin e.code = 4'b0001; e.imm = 1; e.lat = 3 + wait_n; mem = 1; sw = 1; end
    else if (op == 6'h03) begin e.code = 4'b0011; e.lat = 3; e.nreg = 1; e.dst = 2'd2; e.wb = 2'd2; e.ps = 2'd2; end
    else if (op == 6'h05) begin e.code = 4'b0110; e.lat = 3; e.ps = zero ? 2'd0 : 2'd1; end
    else begin e.lat = 2; e.nill = 1; e.ndone = 0; e.npc = 0; end
    if (mem) begin
      e.nreq = wait_n;
      if (wait_n == 0) begin
        e.lat = 3 + TO; e.nbus = 1; e.ndone = 0; e.npc = 0; e.nreg = 0;
        e.wb = 2'd0; e.nreq = TO;
      end
      e.nwe = sw ? e.nreq : 0;
    end
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge of the cycle after the instruction ends.
  task automatic run_instr(input logic [31:0] w, input logic zero, input int wait_n);
    exp_t e;
    int t, lat, nreg, npc, ndone, nill, nbus, nreq, nwe, nrdy, reqcnt;
    logic [3:0] code2, hold;
    logic imm2;
    logic [1:0] dst, wb, ps;
    bit seen;
    e = model(w, zero, wait_n);
    instr = w; instr_valid = 1'b1; alu_zero = zero; mem_ack = 1'b0;
    t = 0;
    while (!instr_ready && t < 20) begin @(negedge clk); t++; end
    if (!instr_ready) begin chk("accept", 0, 1); instr_valid = 1'b0; return; end
    {lat, nreg, npc, ndone, nill, nbus, nreq, nwe, nrdy, reqcnt} = '0;
    code2 = 4'hx; imm2 = 1'bx; hold = 4'hx; dst = 2'bx; wb = 2'bx; ps = 2'bx; seen = 0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      instr_valid = 1'($urandom_range(0, 1));
      instr = $urandom;
      if (k == 2) begin code2 = alu_ctrl; imm2 = alu_src_imm; end
      nreg += int'(reg_we); npc += int'(pc_we); ndone += int'(done);
      nill += int'(illegal); nbus += int'(bus_err); nrdy += int'(instr_ready);
      if (mem_req) begin
        nreq++; nwe += int'(mem_we); reqcnt++;
        mem_ack = (reqcnt == wait_n);
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      if (done || illegal || bus_err) begin
        seen = 1; lat = k; dst = reg_dst; wb = wb_sel; ps = pc_sel; hold = alu_ctrl;
        instr_valid = 1'b0; mem_ack = 1'b0;
      end
    end
    if (!seen) begin
      chk("terminal_seen", 0, 1);
      instr_valid = 1'b0; mem_ack = 1'b0;
    end else begin
      chk("latency", lat, e.lat);
      chk("alu_ctrl", code2, e.code);
      chk("alu_src_imm", imm2, e.imm);
      chk("alu_ctrl_hold", hold, e.code);
      chk("reg_we_count", nreg, e.nreg);
      chk("pc_we_count", npc, e.npc);
      chk("done_count", ndone, e.ndone);
      chk("illegal_count", nill, e.nill);
      chk("bus_err_count", nbus, e.nbus);
      chk("mem_req_cycles", nreq, e.nreq);
      chk("mem_we_cycles", nwe, e.nwe);
      chk("busy_ready", nrdy, 0);
      chk("reg_dst", dst, e.dst);
      chk("wb_sel", wb, e.wb);
      chk("pc_sel", ps, e.ps);
    end
    @(negedge clk);
    chk("ready_after", instr_ready, 1);
    chk("quiet_after", {done, reg_we, pc_we, illegal, bus_err, mem_req}, 0);
  endtask

  function automatic logic [31:0] rand_instr(input int sel);
    logic [31:0] r;
    logic [5:0] op;
    logic [5:0] fn;
    r = $urandom;
    case (sel)
      0: return {6'h00, r[25:6], 6'h21};
      1: return {6'h00, r[25:6], 6'h25};
      2: return {6'h09, r[25:0]};
      3: return {6'h23, r[25:0]};
      4: return {6'h2B, r[25:0]};
      5: return {6'h03, r[25:0]};
      6: return {6'h05, r[25:0]};
      7: begin
        op = 6'($urandom);
        while (op == 6'h00 || op == 6'h09 || op == 6'h2B || op == 6'h23 || op == 6'h03 || op == 6'h05)
          op = 6'($urandom);
        return {op, r[25:0]};
      end
      default: begin
        fn = 6'($urandom);
        while (fn == 6'h21 || fn == 6'h25) fn = 6'($urandom);
        return {6'h00, r[25:6], fn};
      end
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=%0d exp=%0d", 1, 0);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int t, nd, sel, wn;
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; alu_zero = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {instr_ready, alu_ctrl, alu_src_imm, mem_req, mem_we, reg_we, reg_dst,
                          wb_sel, pc_we, pc_sel, done, illegal, bus_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_instr(32'h00851021, 1'b0, 1);
    run_instr(32'h8C820004, 1'b0, 3);
    run_instr(32'h14850003, 1'b0, 1);
    run_instr(32'h14850003, 1'b1, 1);
    run_instr(32'h0C000010, 1'b0, 1);
    run_instr(32'hFC000000, 1'b0, 1);
    run_instr(32'hAC820008, 1'b0, 1);

    // Reset during a store's memory wait must drop mem_req at once and never retire.
    instr = 32'hAC820008; instr_valid = 1'b1; mem_ack = 1'b0;
    t = 0;
    while (!instr_ready && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    instr_valid = 1'b0;
    t = 0;
    while (!mem_req && t < 10) begin @(negedge clk); t++; end
    chk("rst_mem_req_seen", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mem_req_drop", mem_req, 0);
    chk("rst_no_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (4) begin @(negedge clk); nd += int'(done) + int'(reg_we) + int'(pc_we); end
    chk("rst_no_retire", nd, 0);

`ifdef ALU_SEQ_MEM_TIMEOUT_EN
    run_instr(32'hAC820008, 1'b0, 0);
    run_instr(32'h00851021, 1'b0, 1);
`endif

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 8);
      wn = $urandom_range(1, 4);
`ifdef ALU_SEQ_MEM_TIMEOUT_EN
      if ($urandom_range(0, 7) == 0) wn = 0;
`endif
      run_instr(rand_instr(sel), 1'($urandom_range(0, 1)), wn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
